// File: rtl/prog_sequencer.sv
// prog_sequencer
//   Run-level scheduler for the processor core. Sequences NPROG programs
//   back-to-back: for each one the core is held in init for INIT_CYC cycles
//   with its start PC presented, then released until it raises halt or the
//   per-program TIMEOUT expires. The number of RUN cycles with halt low is
//   recorded per program, along with a timeout flag.
//
// Ports
//   CLK            clock, rising edge
//   reset_n        asynchronous active-low reset
//   go             start request, honoured in IDLE or DONE
//   abort          synchronous abort back to IDLE, keeps recorded results
//   prog_base      start-PC table, entry i at [i*PCW +: PCW]
//   core_halt      halt flag from the core
//   core_init      init/PC-load to the core (high outside RUN)
//   core_start_pc  start PC of the current program
//   busy           high in INIT, RUN and NEXT
//   done           high in DONE
//   prog_idx       program being or last sequenced
//   rd_sel         result read select
//   rd_cycles      recorded cycle count of program rd_sel (0 if out of range)
//   tmo_flags      bit i set when program i timed out
module prog_sequencer #(
  parameter int NPROG    = 3,
  parameter int PCW      = 10,
  parameter int CTW      = 16,
  parameter int INIT_CYC = 2,
  parameter int TIMEOUT  = 16'hFFFF
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  input  logic                  go,
  input  logic                  abort,
  input  logic [NPROG*PCW-1:0]  prog_base,
  input  logic                  core_halt,
  output logic                  core_init,
  output logic [PCW-1:0]        core_start_pc,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            prog_idx,
  input  logic [1:0]            rd_sel,
  output logic [CTW-1:0]        rd_cycles,
  output logic [NPROG-1:0]      tmo_flags
);

  localparam int IW = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam logic [IW-1:0]  INIT_LAST = IW'(INIT_CYC - 1);
  localparam logic [CTW-1:0] CNT_LAST  = CTW'(TIMEOUT - 1);
  localparam logic [CTW-1:0] CNT_TMO   = CTW'(TIMEOUT);
  localparam logic [1:0]     IDX_LAST  = 2'(NPROG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_NEXT,
    S_DONE
  } state_t;

  state_t         state;
  logic [CTW-1:0] count;
  logic [IW-1:0]  init_cnt;
  logic [CTW-1:0] cycles [NPROG];

  // Start-PC table lookup, written as a loop so the index never
  // addresses past the end of the table.
  function automatic logic [PCW-1:0] base_pc(input logic [1:0] idx);
    logic [PCW-1:0] pc;
    pc = '0;
    for (int i = 0; i < NPROG; i++) begin
      if (idx == 2'(i)) pc = prog_base[i*PCW +: PCW];
    end
    return pc;
  endfunction

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      core_init     <= 1'b1;
      core_start_pc <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      prog_idx      <= '0;
      count         <= '0;
      init_cnt      <= '0;
      tmo_flags     <= '0;
      for (int i = 0; i < NPROG; i++) cycles[i] <= '0;
    end else if (abort) begin
      // Abort wins over every transition, including a simultaneous go.
      // Results recorded so far are deliberately kept.
      state     <= S_IDLE;
      core_init <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      prog_idx  <= '0;
      count     <= '0;
      init_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            state         <= S_INIT;
            core_init     <= 1'b1;
            busy          <= 1'b1;
            done          <= 1'b0;
            prog_idx      <= '0;
            core_start_pc <= base_pc(2'd0);
            count         <= '0;
            init_cnt      <= '0;
            tmo_flags     <= '0;
            for (int i = 0; i < NPROG; i++) cycles[i] <= '0;
          end
        end

        S_INIT: begin
          // core_halt is ignored while the core is held in init.
          if (init_cnt == INIT_LAST) begin
            state     <= S_RUN;
            core_init <= 1'b0;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end

        S_RUN: begin
          // Halt takes priority over the timeout, so a halt on the last
          // allowed cycle records TIMEOUT-1 without the flag.
          if (core_halt) begin
            cycles[prog_idx] <= count;
            state            <= S_NEXT;
            core_init        <= 1'b1;
          end else if (count == CNT_LAST) begin
            cycles[prog_idx]    <= CNT_TMO;
            tmo_flags[prog_idx] <= 1'b1;
            state               <= S_NEXT;
            core_init           <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end

        S_NEXT: begin
          if (prog_idx == IDX_LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state         <= S_INIT;
            prog_idx      <= prog_idx + 2'd1;
            core_start_pc <= base_pc(prog_idx + 2'd1);
            count         <= '0;
            init_cnt      <= '0;
          end
        end

        default: begin
          state     <= S_IDLE;
          core_init <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  // Combinational result read; out-of-range selects return zero.
  always_comb begin
    rd_cycles = '0;
    for (int i = 0; i < NPROG; i++) begin
      if (rd_sel == 2'(i)) rd_cycles = cycles[i];
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer
//   Self-checking bench for prog_sequencer with NPROG=3, INIT_CYC=2,
//   TIMEOUT=100. A small core model raises halt a programmed number of RUN
//   cycles after core_init falls, choosing its target from the start PC.
//   Expected start PCs and cycle counts are queued when a run is launched
//   and popped when the DUT produces them.
`timescale 1ns/1ps
module tb_prog_sequencer;

  localparam int NPROG    = 3;
  localparam int PCW      = 10;
  localparam int CTW      = 16;
  localparam int INIT_CYC = 2;
  localparam int TIMEOUT  = 100;

  logic                 CLK = 1'b0;
  logic                 reset_n = 1'b1;
  logic                 go = 1'b0;
  logic                 abort = 1'b0;
  logic [NPROG*PCW-1:0] prog_base = {10'h200, 10'h100, 10'h000};
  logic                 core_halt = 1'b0;
  logic                 core_init;
  logic [PCW-1:0]       core_start_pc;
  logic                 busy;
  logic                 done;
  logic [1:0]           prog_idx;
  logic [1:0]           rd_sel = 2'd0;
  logic [CTW-1:0]       rd_cycles;
  logic [NPROG-1:0]     tmo_flags;

  prog_sequencer #(
    .NPROG(NPROG), .PCW(PCW), .CTW(CTW), .INIT_CYC(INIT_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .reset_n(reset_n), .go(go), .abort(abort),
    .prog_base(prog_base), .core_halt(core_halt), .core_init(core_init),
    .core_start_pc(core_start_pc), .busy(busy), .done(done),
    .prog_idx(prog_idx), .rd_sel(rd_sel), .rd_cycles(rd_cycles),
    .tmo_flags(tmo_flags)
  );

  always #10 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // Core model state: halt target per program (-1 = never halts).
  int tgt [4] = '{-1, -1, -1, -1};
  bit hold_in_init = 1'b0;
  int rc = 0;

  logic [PCW-1:0] exp_pc_q [$];
  int             exp_cyc_q [$];
  logic           prev_init = 1'b1;

  typedef struct {
    int         t0, t1, t2;
    bit         hold;
    int         e0, e1, e2;
    logic [2:0] tmo;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Core model: halt goes high on RUN cycle k == target (k counted from 0).
  always @(negedge CLK) begin
    int k;
    k = int'(core_start_pc[9:8]);
    if (core_init !== 1'b0) begin
      rc = 0;
      core_halt = hold_in_init;
    end else begin
      core_halt = (tgt[k] >= 0) && (rc == tgt[k]);
      rc++;
    end
  end

  // Start-PC monitor: the PC presented when the core leaves init.
  always @(negedge CLK) begin
    if (prev_init === 1'b1 && core_init === 1'b0) begin
      if (exp_pc_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL core_start_pc: unexpected RUN entry with pc 0x%0h, none expected", core_start_pc);
      end else begin
        check("core_start_pc", 32'(core_start_pc), 32'(exp_pc_q.pop_front()));
      end
    end
    prev_init = core_init;
  end

  function automatic int run_len(input int t);
    return (t < 0) ? TIMEOUT : t + 1;
  endfunction

  // go sampled at edge E -> done visible after E+lat; each program spends
  // INIT_CYC init cycles, its RUN cycles (including the halt cycle) and
  // one NEXT cycle.
  function automatic int exp_lat(input int t0, input int t1, input int t2);
    return 3 * (INIT_CYC + 1) + run_len(t0) + run_len(t1) + run_len(t2);
  endfunction

  task automatic check_rd(input int i, input int exp);
    rd_sel = 2'(i);
    #1;
    check($sformatf("rd_cycles[%0d]", i), 32'(rd_cycles), 32'(exp));
  endtask

  // Called at a negedge; returns at the negedge after go was sampled.
  task automatic start_run(input int t0, input int t1, input int t2, input bit hold,
                           input int e0, input int e1, input int e2);
    tgt[0] = t0;
    tgt[1] = t1;
    tgt[2] = t2;
    hold_in_init = hold;
    exp_pc_q.push_back(10'h000);
    exp_pc_q.push_back(10'h100);
    exp_pc_q.push_back(10'h200);
    exp_cyc_q.push_back(e0);
    exp_cyc_q.push_back(e1);
    exp_cyc_q.push_back(e2);
    go = 1'b1;
    @(negedge CLK);
    go = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 2000) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
    if (done !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, lat);
    end
  endtask

  task automatic wait_run1();
    int n;
    n = 0;
    while (!(prog_idx === 2'd1 && core_init === 1'b0) && n < 500) begin
      @(negedge CLK);
      n++;
    end
    if (!(prog_idx === 2'd1 && core_init === 1'b0)) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_run1: prog_idx=%0d core_init=%b, required 1/0", prog_idx, core_init);
    end
  endtask

  task automatic check_results();
    for (int i = 0; i < NPROG; i++) begin
      if (exp_cyc_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL result_queue: no expected value for program %0d", i);
      end else begin
        check_rd(i, exp_cyc_q.pop_front());
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_core_init"}, 32'(core_init), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_prog_idx"}, 32'(prog_idx), 0);
    check({tag, "_tmo_flags"}, 32'(tmo_flags), 0);
    check({tag, "_core_start_pc"}, 32'(core_start_pc), 0);
    for (int i = 0; i < NPROG; i++) check_rd(i, 0);
  endtask

  initial begin
    int lat;

    vecs[0] = '{t0: 10, t1: 25, t2: 7,  hold: 1'b0, e0: 10, e1: 25,  e2: 7, tmo: 3'b000};
    vecs[1] = '{t0: 0,  t1: 3,  t2: 0,  hold: 1'b1, e0: 0,  e1: 3,   e2: 0, tmo: 3'b000};
    vecs[2] = '{t0: 99, t1: 5,  t2: 0,  hold: 1'b0, e0: 99, e1: 5,   e2: 0, tmo: 3'b000};
    vecs[3] = '{t0: 10, t1: -1, t2: 7,  hold: 1'b0, e0: 10, e1: 100, e2: 7, tmo: 3'b010};

    // Reset asserted between edges takes effect without a clock edge.
    #2 reset_n = 1'b0;
    #1;
    check_reset_vals("reset");
    @(negedge CLK);
    @(negedge CLK);
    reset_n = 1'b1;
    @(negedge CLK);
    check("idle_busy", 32'(busy), 0);
    check("idle_core_init", 32'(core_init), 1);

    // Table-driven full runs.
    for (int v = 0; v < 4; v++) begin
      start_run(vecs[v].t0, vecs[v].t1, vecs[v].t2, vecs[v].hold,
                vecs[v].e0, vecs[v].e1, vecs[v].e2);
      wait_done(lat);
      check($sformatf("v%0d_done_latency", v), 32'(lat),
            32'(exp_lat(vecs[v].t0, vecs[v].t1, vecs[v].t2)));
      check_results();
      check($sformatf("v%0d_tmo_flags", v), 32'(tmo_flags), 32'(vecs[v].tmo));
      check($sformatf("v%0d_prog_idx", v), 32'(prog_idx), 2);
      check($sformatf("v%0d_busy", v), 32'(busy), 0);
      check($sformatf("v%0d_core_init", v), 32'(core_init), 1);
    end

    // Restart from DONE (previous run left a timeout flag and results).
    start_run(10, 25, 7, 1'b0, 10, 25, 7);
    for (int i = 0; i < NPROG; i++) check_rd(i, 0);
    check("restart_tmo_flags", 32'(tmo_flags), 0);
    check("restart_prog_idx", 32'(prog_idx), 0);
    check("restart_busy", 32'(busy), 1);
    check("restart_done", 32'(done), 0);
    check("restart_init1", 32'(core_init), 1);
    @(negedge CLK);
    check("restart_init2", 32'(core_init), 1);
    @(negedge CLK);
    check("restart_run", 32'(core_init), 0);
    wait_done(lat);
    check_results();
    check("restart_tmo_final", 32'(tmo_flags), 0);

    // go during RUN is ignored, then abort during program 1.
    start_run(10, 25, 7, 1'b0, 10, 25, 7);
    wait_run1();
    go = 1'b1;
    @(negedge CLK);
    go = 1'b0;
    check("busy_go_prog_idx", 32'(prog_idx), 1);
    check("busy_go_busy", 32'(busy), 1);
    check("busy_go_core_init", 32'(core_init), 0);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    exp_pc_q.delete();
    exp_cyc_q.delete();
    check("abort_busy", 32'(busy), 0);
    check("abort_core_init", 32'(core_init), 1);
    check("abort_prog_idx", 32'(prog_idx), 0);
    check("abort_done", 32'(done), 0);
    check_rd(0, 10);
    check_rd(1, 0);
    check_rd(2, 0);

    // go and abort together: abort wins, stays IDLE.
    go = 1'b1;
    abort = 1'b1;
    @(negedge CLK);
    go = 1'b0;
    abort = 1'b0;
    check("go_abort_busy", 32'(busy), 0);
    check("go_abort_core_init", 32'(core_init), 1);
    @(negedge CLK);
    check("go_abort_busy_later", 32'(busy), 0);
    check_rd(0, 10);

    // Reset mid-run discards everything immediately.
    start_run(10, 25, 7, 1'b0, 10, 25, 7);
    wait_run1();
    #3 reset_n = 1'b0;
    #1;
    check_reset_vals("midrun_reset");
    exp_pc_q.delete();
    exp_cyc_q.delete();
    @(negedge CLK);
    @(negedge CLK);
    reset_n = 1'b1;
    @(negedge CLK);
    check("post_reset_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
